// File: rtl/spi_slave_param.sv
// Oversampled full-duplex SPI slave: any CPOL/CPHA, parametrised width and bit order,
// single-word holding buffer feeding the MISO shifter.
//
// state  | meaning
// IDLE   | synced cs_n high; sclk edges ignored, miso_oe low
// ACTIVE | frame in progress; sample/shift edges processed, words back to back
module spi_slave_param #(
    parameter int DATA_W      = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic              frame_active
);
    localparam int   CNT_W    = $clog2(DATA_W);
    localparam logic IDLE_LVL = (CPOL != 0);
    localparam bit   PHASE1   = (CPHA != 0);
    localparam bit   MSB      = (MSB_FIRST != 0);

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;

    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] tx_hold;

    logic sclk_new, sclk_old, mosi_s;
    logic lead, trail, sample_edge, shift_edge;
    logic cs_fall, cs_rise;
    logic frame_start, frame_end, do_sample, do_shift, word_start, emit;
    logic [DATA_W-1:0] rx_next, reload_word, tx_src, tx_shifted;
    logic              tx_first;

    // Input synchronisers; bit 0 is the newest sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= {SYNC_STAGES{IDLE_LVL}};
            cs_sync   <= {SYNC_STAGES{1'b1}};
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    assign sclk_new     = sclk_sync[SYNC_STAGES-2];
    assign sclk_old     = sclk_sync[SYNC_STAGES-1];
    assign mosi_s       = mosi_sync[SYNC_STAGES-2];
    assign lead         = (sclk_old == IDLE_LVL) && (sclk_new != IDLE_LVL);
    assign trail        = (sclk_old != IDLE_LVL) && (sclk_new == IDLE_LVL);
    assign sample_edge  = PHASE1 ? trail : lead;
    assign shift_edge   = PHASE1 ? lead : trail;
    assign cs_fall      = cs_sync[SYNC_STAGES-1] & ~cs_sync[SYNC_STAGES-2];
    assign cs_rise      = ~cs_sync[SYNC_STAGES-1] & cs_sync[SYNC_STAGES-2];
    assign frame_active = ~cs_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        do_sample   = 1'b0;
        do_shift    = 1'b0;
        word_start  = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next  = ACTIVE;
                    frame_start = 1'b1;
                    word_start  = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    frame_end  = 1'b1;
                end else begin
                    word_start = rx_valid;
                    do_sample  = sample_edge;
                    do_shift   = shift_edge;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // With CPHA=0 the master samples bit 0 before any shift edge, so it is driven at frame start.
    assign emit        = do_shift | (frame_start & ~PHASE1);
    assign reload_word = tx_ready ? '0 : tx_hold;
    assign tx_src      = word_start ? reload_word : tx_shift;
    assign tx_first    = MSB ? tx_src[DATA_W-1] : tx_src[0];
    assign tx_shifted  = MSB ? {tx_src[DATA_W-2:0], 1'b0} : {1'b0, tx_src[DATA_W-1:1]};
    assign rx_next     = MSB ? {rx_shift[DATA_W-2:0], mosi_s} : {mosi_s, rx_shift[DATA_W-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_ready    <= 1'b1;
            tx_underrun <= 1'b0;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            tx_hold     <= '0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;

            if (frame_start) miso_oe <= 1'b1;

            if (frame_end) begin
                miso_oe  <= 1'b0;
                miso     <= 1'b0;
                bit_cnt  <= '0;
                rx_shift <= '0;
            end

            if (do_sample) begin
                rx_shift <= rx_next;
                if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                    bit_cnt  <= '0;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end

            if (emit) begin
                miso     <= tx_first;
                tx_shift <= tx_shifted;
            end else if (word_start) begin
                tx_shift <= reload_word;
            end

            if (word_start && tx_ready) tx_underrun <= 1'b1;

            // A load in the reload cycle is still captured; the reload itself saw the old buffer.
            if (tx_load && tx_ready) begin
                tx_hold  <= tx_data;
                tx_ready <= 1'b0;
            end else if (word_start) begin
                tx_ready <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: four 8-bit MSB-first instances (modes 0..3) and one
// 16-bit LSB-first mode-0 instance, driven by a bit-level SPI master model.
module tb_spi_slave_param;
    localparam int ND = 5;
    localparam int H  = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        sclk_a [ND];
    logic        cs_a   [ND];
    logic        mosi_a [ND];
    logic        load_a [ND];
    logic [15:0] txd_a  [ND];
    wire         miso_a [ND];
    wire         oe_a   [ND];
    wire         rxv_a  [ND];
    wire         rdy_a  [ND];
    wire         und_a  [ND];
    wire         fa_a   [ND];
    wire  [15:0] rxd_a  [ND];

    for (genvar g = 0; g < 4; g++) begin : g_mode
        wire [7:0] rxd8;
        spi_slave_param #(
            .DATA_W(8), .CPOL(g / 2), .CPHA(g % 2), .MSB_FIRST(1), .SYNC_STAGES(2)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .sclk(sclk_a[g]), .cs_n(cs_a[g]), .mosi(mosi_a[g]),
            .miso(miso_a[g]), .miso_oe(oe_a[g]), .rx_data(rxd8), .rx_valid(rxv_a[g]),
            .tx_data(txd_a[g][7:0]), .tx_load(load_a[g]), .tx_ready(rdy_a[g]),
            .tx_underrun(und_a[g]), .frame_active(fa_a[g])
        );
        assign rxd_a[g] = {8'h00, rxd8};
    end

    spi_slave_param #(
        .DATA_W(16), .CPOL(0), .CPHA(0), .MSB_FIRST(0), .SYNC_STAGES(3)
    ) u_dut16 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk_a[4]), .cs_n(cs_a[4]), .mosi(mosi_a[4]),
        .miso(miso_a[4]), .miso_oe(oe_a[4]), .rx_data(rxd_a[4]), .rx_valid(rxv_a[4]),
        .tx_data(txd_a[4]), .tx_load(load_a[4]), .tx_ready(rdy_a[4]),
        .tx_underrun(und_a[4]), .frame_active(fa_a[4])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cpol_of(input int m);  return (m < 4) ? m / 2 : 0; endfunction
    function automatic int cpha_of(input int m);  return (m < 4) ? m % 2 : 0; endfunction
    function automatic int width_of(input int m); return (m < 4) ? 8 : 16;    endfunction
    function automatic bit msb_of(input int m);   return (m < 4);             endfunction

    // Per-instance log of received words and underrun pulses.
    int          rxv_cnt [ND] = '{0, 0, 0, 0, 0};
    int          und_cnt [ND] = '{0, 0, 0, 0, 0};
    logic [15:0] rx_hist [ND][64];

    always @(negedge clk) begin
        for (int i = 0; i < ND; i++) begin
            if (rxv_a[i] === 1'b1) begin
                rx_hist[i][rxv_cnt[i] % 64] <= rxd_a[i];
                rxv_cnt[i] <= rxv_cnt[i] + 1;
            end
            if (und_a[i] === 1'b1) und_cnt[i] <= und_cnt[i] + 1;
        end
    end

    logic [15:0] mo_w [4];
    logic [15:0] mi_w [4];
    logic [15:0] tx_w [4];

    task automatic load_word(input int m, input logic [15:0] v);
        int n;
        n = 0;
        while (rdy_a[m] !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_before_load", 32'(rdy_a[m]), 32'd1);
        txd_a[m]  = v;
        load_a[m] = 1'b1;
        @(negedge clk);
        load_a[m] = 1'b0;
        check("tx_ready_after_load", 32'(rdy_a[m]), 32'd0);
    endtask

    // Master: one frame of nbits bits, words taken from mo_w, MISO bits gathered into mi_w.
    task automatic run_frame(input int m, input int nbits);
        int   w, wi, bi;
        logic pol, ph;
        w   = width_of(m);
        pol = (cpol_of(m) != 0);
        ph  = (cpha_of(m) != 0);
        for (int i = 0; i < 4; i++) mi_w[i] = '0;
        cs_a[m] = 1'b0;
        repeat (2 * H) @(negedge clk);
        check("frame_active_in_frame", 32'(fa_a[m]), 32'd1);
        check("miso_oe_in_frame", 32'(oe_a[m]), 32'd1);
        for (int k = 0; k < nbits; k++) begin
            wi = k / w;
            bi = msb_of(m) ? (w - 1 - (k % w)) : (k % w);
            if (!ph) begin
                mosi_a[m] = mo_w[wi][bi];
                repeat (H) @(negedge clk);
                mi_w[wi][bi] = miso_a[m];
                sclk_a[m] = ~pol;
                repeat (H) @(negedge clk);
                sclk_a[m] = pol;
            end else begin
                repeat (H) @(negedge clk);
                sclk_a[m] = ~pol;
                mosi_a[m] = mo_w[wi][bi];
                repeat (H) @(negedge clk);
                mi_w[wi][bi] = miso_a[m];
                sclk_a[m] = pol;
            end
        end
        repeat (2 * H) @(negedge clk);
        cs_a[m]   = 1'b1;
        mosi_a[m] = 1'b0;
        repeat (4 * H) @(negedge clk);
        check("frame_active_after", 32'(fa_a[m]), 32'd0);
        check("miso_oe_after", 32'(oe_a[m]), 32'd0);
        check("miso_after", 32'(miso_a[m]), 32'd0);
    endtask

    // pre: 0 = nothing loaded, 1 = load tx_w[0] here, 2 = tx_w[0] already loaded.
    // Every word start (frame start, and after each full word) takes a loaded word or underruns.
    task automatic exchange(input int m, input int nw, input int pre);
        int          rv0, un0, nl;
        logic [15:0] mask;
        mask = (width_of(m) == 16) ? 16'hFFFF : 16'h00FF;
        rv0  = rxv_cnt[m];
        un0  = und_cnt[m];
        nl   = (pre != 0) ? nw : 0;
        if (pre == 1) load_word(m, tx_w[0]);
        fork
            run_frame(m, nw * width_of(m));
            begin
                if (pre != 0) for (int i = 1; i < nw; i++) load_word(m, tx_w[i]);
            end
        join
        check("rx_valid_count", 32'(rxv_cnt[m] - rv0), 32'(nw));
        check("underrun_count", 32'(und_cnt[m] - un0), 32'(nw + 1 - nl));
        for (int i = 0; i < nw; i++) begin
            check("rx_word", 32'(rx_hist[m][(rv0 + i) % 64]), 32'(mo_w[i] & mask));
            check("miso_word", 32'(mi_w[i]), (i < nl) ? 32'(tx_w[i] & mask) : 32'd0);
        end
        check("rx_data_last", 32'(rxd_a[m]), 32'(mo_w[nw - 1] & mask));
        check("tx_ready_end", 32'(rdy_a[m]), 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          rv0, un0, nw, pre;
        logic [15:0] mask;
        rst_n = 1'b0;
        for (int m = 0; m < ND; m++) begin
            sclk_a[m] = (cpol_of(m) != 0);
            cs_a[m]   = 1'b1;
            mosi_a[m] = 1'b0;
            load_a[m] = 1'b0;
            txd_a[m]  = '0;
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int m = 0; m < ND; m++) begin
            check("rst_miso", 32'(miso_a[m]), 32'd0);
            check("rst_miso_oe", 32'(oe_a[m]), 32'd0);
            check("rst_rx_data", 32'(rxd_a[m]), 32'd0);
            check("rst_rx_valid", 32'(rxv_a[m]), 32'd0);
            check("rst_tx_ready", 32'(rdy_a[m]), 32'd1);
            check("rst_underrun", 32'(und_a[m]), 32'd0);
            check("rst_frame_active", 32'(fa_a[m]), 32'd0);
        end

        // Mode 0 exchange; a second load while the buffer is full must be dropped.
        mo_w[0] = 16'h00A5;
        tx_w[0] = 16'h003C;
        load_word(0, 16'h003C);
        txd_a[0]  = 16'h00FF;
        load_a[0] = 1'b1;
        @(negedge clk);
        load_a[0] = 1'b0;
        check("tx_ready_load_ignored", 32'(rdy_a[0]), 32'd0);
        exchange(0, 1, 2);

        for (int m = 1; m < 4; m++) begin
            mo_w[0] = 16'h00C3;
            tx_w[0] = 16'h005A;
            exchange(m, 1, 1);
        end

        // Frame aborted after 5 bits, then a clean word.
        mo_w[0] = 16'($urandom) & 16'h00FF;
        rv0 = rxv_cnt[0];
        un0 = und_cnt[0];
        run_frame(0, 5);
        check("partial_no_rx_valid", 32'(rxv_cnt[0] - rv0), 32'd0);
        check("partial_underrun", 32'(und_cnt[0] - un0), 32'd1);
        mo_w[0] = 16'h0081;
        tx_w[0] = 16'($urandom) & 16'h00FF;
        exchange(0, 1, 1);

        mo_w[0] = 16'h0011; mo_w[1] = 16'h0022; mo_w[2] = 16'h0033;
        for (int i = 0; i < 3; i++) tx_w[i] = 16'($urandom) & 16'h00FF;
        exchange(0, 3, 1);

        mo_w[0] = 16'($urandom) & 16'h00FF;
        exchange(1, 1, 0);

        mo_w[0] = 16'hBEEF;
        tx_w[0] = 16'($urandom);
        exchange(4, 1, 1);

        // Reset pulse in the middle of a mode-0 word.
        rv0 = rxv_cnt[0];
        cs_a[0] = 1'b0;
        repeat (2 * H) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            mosi_a[0] = k[0];
            repeat (H) @(negedge clk);
            sclk_a[0] = 1'b1;
            repeat (H) @(negedge clk);
            if (k < 3) sclk_a[0] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_miso", 32'(miso_a[0]), 32'd0);
        check("midrst_miso_oe", 32'(oe_a[0]), 32'd0);
        check("midrst_rx_data", 32'(rxd_a[0]), 32'd0);
        check("midrst_tx_ready", 32'(rdy_a[0]), 32'd1);
        check("midrst_frame_active", 32'(fa_a[0]), 32'd0);
        sclk_a[0] = 1'b0;
        cs_a[0]   = 1'b1;
        mosi_a[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4 * H) @(negedge clk);
        check("midrst_no_rx_valid", 32'(rxv_cnt[0] - rv0), 32'd0);
        mo_w[0] = 16'h007E;
        tx_w[0] = 16'($urandom) & 16'h00FF;
        exchange(0, 1, 1);

        // Randomised frames over every instance.
        for (int r = 0; r < 3; r++) begin
            for (int m = 0; m < ND; m++) begin
                mask = (width_of(m) == 16) ? 16'hFFFF : 16'h00FF;
                nw   = int'($urandom_range(1, 3));
                pre  = ($urandom_range(0, 3) == 0) ? 0 : 1;
                for (int i = 0; i < 4; i++) begin
                    mo_w[i] = 16'($urandom) & mask;
                    tx_w[i] = 16'($urandom) & mask;
                end
                exchange(m, nw, pre);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
